ras_predictor: RTL and testbench



---
 rtl/ras_predictor_pkg.sv | 25 ++
 rtl/ras_predictor_call_stack.sv | 71 +++++++
 rtl/ras_predictor.sv | 136 +++++++++++++
 tb/tb_ras_predictor.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_predictor_pkg.sv
// ras_predictor_pkg
// Shared RV32I core definitions used by the return-address predictor:
// opcode and register encodings for the link-register hint rules, the
// canonical NOP, and the stack-operation enum produced by decode.
package ras_predictor_pkg;

    localparam logic [6:0]  OPC_JAL   = 7'b1101111;
    localparam logic [6:0]  OPC_JALR  = 7'b1100111;
    localparam logic [4:0]  REG_RA    = 5'd1;
    localparam logic [4:0]  REG_T0    = 5'd5;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_SWAP
    } ras_op_t;

    // x1 (ra) and x5 (t0) are both treated as link registers.
    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/ras_predictor_call_stack.sv
// call_stack
// Circular return-address stack. A push while full overwrites the oldest
// entry by pointer wrap; a pop on an empty stack is ignored; a pop and push
// together replace the top entry and leave the count unchanged.
// Ports:
//   clk, aresetn   clock, asynchronous active-low reset
//   push, pop      operation enables (already qualified by the caller)
//   push_data      value written on push
//   top            current top-of-stack entry
//   full, empty    occupancy flags
module call_stack #(
    parameter int DPT = 8,
    parameter int DW  = 32
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic [DW-1:0] top,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(DPT);
    localparam int CW = $clog2(DPT) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DPT);

    logic [DW-1:0] mem [DPT];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] top_ptr;
    logic [CW-1:0] count;
    logic          pop_eff;

    assign top_ptr = wr_ptr - PW'(1);
    assign pop_eff = pop & ~empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign top     = mem[top_ptr];

    // Pointer and occupancy tracking. The write pointer always names the
    // next free slot, so the top lives one below it. Once full, further
    // pushes keep advancing the pointer (dropping the oldest frame) while the
    // count saturates at the depth.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (pop_eff && !push) begin
            wr_ptr <= top_ptr;
            count  <= count - CW'(1);
        end else if (push && !pop_eff) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end
    end

    // Entry storage has no reset; the count alone decides what is live.
    // A combined pop and push rewrites the current top in place.
    always_ff @(posedge clk) begin
        if (push && aresetn) begin
            if (pop_eff) begin
                mem[top_ptr] <= push_data;
            end else begin
                mem[wr_ptr] <= push_data;
            end
        end
    end

endmodule

// File: rtl/ras_predictor.sv
// ras_predictor
// Fetch-side return-address predictor. Classifies each accepted instruction
// as call / return / coroutine swap using the link-register hint rules,
// drives a call_stack with PC+4 pushes and return pops, and forwards the
// instruction through a one-deep valid/ready register with a predicted
// redirect target.
// Optional feature: define RAS_JAL_PRED_EN to also predict every JAL target
// (PC + J-immediate). Without it only returns produce a prediction.
// Ports:
//   clk, aresetn                   clock, asynchronous active-low reset
//   i_flush                        kills the current input and output register
//   i_pc, i_instr, i_valid, o_ready   upstream handshake
//   o_pc, o_instr, o_valid, i_ready   downstream handshake
//   o_pred_vld, o_pred_target      predicted redirect
//   o_ras_full, o_ras_empty        stack status flags
module ras_predictor
    import ras_predictor_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int RAS_DPT = 8
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            i_flush,
    input  logic [PC_W-1:0] i_pc,
    input  logic [31:0]     i_instr,
    input  logic            i_valid,
    output logic            o_ready,
    output logic [PC_W-1:0] o_pc,
    output logic [31:0]     o_instr,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_pred_vld,
    output logic [PC_W-1:0] o_pred_target,
    output logic            o_ras_full,
    output logic            o_ras_empty
);

    function automatic ras_op_t decode_op(input logic [31:0] instr);
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       rd_link;
        logic       rs1_link;
        rd       = instr[11:7];
        rs1      = instr[19:15];
        rd_link  = is_link(rd);
        rs1_link = is_link(rs1);
        decode_op = RAS_NONE;
        if (instr[6:0] == OPC_JAL) begin
            if (rd_link) begin
                decode_op = RAS_PUSH;
            end
        end else if (instr[6:0] == OPC_JALR) begin
            if (rd_link && !rs1_link) begin
                decode_op = RAS_PUSH;
            end else if (!rd_link && rs1_link) begin
                decode_op = RAS_POP;
            end else if (rd_link && rs1_link) begin
                decode_op = (rs1 != rd) ? RAS_SWAP : RAS_PUSH;
            end
        end
    endfunction

    ras_op_t         op;
    logic            fire;
    logic            stack_push;
    logic            stack_pop;
    logic [PC_W-1:0] stack_top;
    logic            pred_vld_d;
    logic [PC_W-1:0] pred_target_d;

    assign o_ready = ~o_valid | i_ready;
    assign fire    = i_valid & o_ready & ~i_flush;
    assign op      = decode_op(i_instr);

`ifdef RAS_JAL_PRED_EN
    logic [20:0] jal_imm;
    assign jal_imm = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
`endif

    // Stack enables are qualified by fire so flushed or stalled inputs never
    // touch the speculative stack. A return predicts the top as it stands
    // before this edge's pop/push takes effect.
    always_comb begin
        stack_push    = fire & ((op == RAS_PUSH) | (op == RAS_SWAP));
        stack_pop     = fire & ((op == RAS_POP)  | (op == RAS_SWAP));
        pred_vld_d    = ((op == RAS_POP) | (op == RAS_SWAP)) & ~o_ras_empty;
        pred_target_d = pred_vld_d ? stack_top : '0;
`ifdef RAS_JAL_PRED_EN
        if (i_instr[6:0] == OPC_JAL) begin
            pred_vld_d    = 1'b1;
            pred_target_d = i_pc + {{(PC_W-21){jal_imm[20]}}, jal_imm};
        end
`endif
    end

    call_stack #(
        .DPT (RAS_DPT),
        .DW  (PC_W)
    ) u_call_stack (
        .clk       (clk),
        .aresetn   (aresetn),
        .push      (stack_push),
        .pop       (stack_pop),
        .push_data (i_pc + PC_W'(4)),
        .top       (stack_top),
        .full      (o_ras_full),
        .empty     (o_ras_empty)
    );

    // Output register stage. Flush wins over everything, then a new fire
    // loads, otherwise a consumed entry is retired. The prediction flag is
    // retired with the valid so it never appears without an instruction.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_valid       <= 1'b0;
            o_pc          <= '0;
            o_instr       <= NOP_INSTR;
            o_pred_vld    <= 1'b0;
            o_pred_target <= '0;
        end else if (i_flush) begin
            o_valid    <= 1'b0;
            o_pred_vld <= 1'b0;
        end else if (fire) begin
            o_valid       <= 1'b1;
            o_pc          <= i_pc;
            o_instr       <= i_instr;
            o_pred_vld    <= pred_vld_d;
            o_pred_target <= pred_target_d;
        end else if (o_valid && i_ready) begin
            o_valid    <= 1'b0;
            o_pred_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ras_predictor.sv
// tb_ras_predictor
// Self-checking bench for ras_predictor: a table of instruction records with
// expected predictions and stack flags is streamed back-to-back, expected
// outputs are queued as each instruction is driven and matched when the
// downstream handshake completes; hand-written sequences cover backpressure,
// flush and mid-stream reset.
module tb_ras_predictor;

`ifdef RAS_JAL_PRED_EN
    localparam bit JAL_PRED = 1'b1;
`else
    localparam bit JAL_PRED = 1'b0;
`endif

    logic        clk;
    logic        aresetn;
    logic        i_flush;
    logic [31:0] i_pc;
    logic [31:0] i_instr;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_valid;
    logic        i_ready;
    logic        o_pred_vld;
    logic [31:0] o_pred_target;
    logic        o_ras_full;
    logic        o_ras_empty;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exp_vld;
        logic [31:0] exp_target;
        logic        exp_empty;
        logic        exp_full;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        vld;
        logic [31:0] target;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    ras_predictor #(
        .PC_W    (32),
        .RAS_DPT (8)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .i_flush       (i_flush),
        .i_pc          (i_pc),
        .i_instr       (i_instr),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .o_pc          (o_pc),
        .o_instr       (o_instr),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_pred_vld    (o_pred_vld),
        .o_pred_target (o_pred_target),
        .o_ras_full    (o_ras_full),
        .o_ras_empty   (o_ras_empty)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] encJal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] encJalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic addRow(input logic [31:0] pc, input logic [31:0] instr, input logic vld,
                          input logic [31:0] target, input logic empty, input logic full);
        vec_t v;
        v.pc = pc; v.instr = instr; v.exp_vld = vld; v.exp_target = target;
        v.exp_empty = empty; v.exp_full = full;
        vecs.push_back(v);
    endtask

    task automatic addJal(input logic [31:0] pc, input logic [4:0] rd, input logic [20:0] imm,
                          input logic empty, input logic full);
        logic [31:0] tgt;
        tgt = pc + {{11{imm[20]}}, imm};
        addRow(pc, encJal(rd, imm), JAL_PRED, JAL_PRED ? tgt : 32'h0, empty, full);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one instruction for one cycle (caller sits just after an edge),
    // queues its expected output, then checks the stack flags after the edge.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        i_pc    = v.pc;
        i_instr = v.instr;
        i_valid = 1'b1;
        e.pc = v.pc; e.instr = v.instr; e.vld = v.exp_vld; e.target = v.exp_target;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checkOutput("ras_empty", {31'h0, o_ras_empty}, {31'h0, v.exp_empty});
        checkOutput("ras_full",  {31'h0, o_ras_full},  {31'h0, v.exp_full});
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues();
        checkOutput("rst_o_valid",    {31'h0, o_valid},     32'h0);
        checkOutput("rst_o_pred_vld", {31'h0, o_pred_vld},  32'h0);
        checkOutput("rst_o_target",   o_pred_target,        32'h0);
        checkOutput("rst_o_pc",       o_pc,                 32'h0);
        checkOutput("rst_o_instr",    o_instr,              32'h0000_0013);
        checkOutput("rst_ras_empty",  {31'h0, o_ras_empty}, 32'h1);
        checkOutput("rst_ras_full",   {31'h0, o_ras_full},  32'h0);
        checkOutput("rst_o_ready",    {31'h0, o_ready},     32'h1);
    endtask

    // Scoreboard monitor: each completed downstream transfer is matched
    // against the oldest queued expectation.
    always @(negedge clk) begin
        if (aresetn && o_valid && i_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got pc %h expected no output", o_pc);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("o_pc",       o_pc,                mon_e.pc);
                checkOutput("o_instr",    o_instr,             mon_e.instr);
                checkOutput("o_pred_vld", {31'h0, o_pred_vld}, {31'h0, mon_e.vld});
                if (mon_e.vld) begin
                    checkOutput("o_pred_target", o_pred_target, mon_e.target);
                end
            end
        end
    end

    initial begin
        logic [31:0] ret1;
        logic [31:0] ret5;
        ret1 = encJalr(5'd0, 5'd1);
        ret5 = encJalr(5'd0, 5'd5);

        // Call / return, non-control, empty return, non-link JAL.
        addJal(32'h100, 5'd1, 21'h300, 1'b0, 1'b0);
        addRow(32'h400, ret1, 1'b1, 32'h104, 1'b1, 1'b0);
        addRow(32'h404, 32'h0000_0013, 1'b0, 32'h0, 1'b1, 1'b0);
        addRow(32'h408, ret1, 1'b0, 32'h0, 1'b1, 1'b0);
        addJal(32'h40c, 5'd0, 21'h040, 1'b1, 1'b0);
        // Nested overflow: 9 calls into an 8-deep stack, then 9 returns.
        for (int k = 0; k < 9; k++) begin
            addJal(32'(16 * k), 5'd1, 21'h040, 1'b0, (k >= 7));
        end
        for (int j = 0; j < 8; j++) begin
            addRow(32'h500 + 32'(4 * j), ret1, 1'b1, 32'h84 - 32'(16 * j), (j == 7), 1'b0);
        end
        addRow(32'h520, ret1, 1'b0, 32'h0, 1'b1, 1'b0);
        // Coroutine swap keeps the count and replaces the top.
        addJal(32'h200, 5'd1, 21'h040, 1'b0, 1'b0);
        addRow(32'h300, encJalr(5'd5, 5'd1), 1'b1, 32'h204, 1'b0, 1'b0);
        addRow(32'h310, ret5, 1'b1, 32'h304, 1'b1, 1'b0);
        // JALR push forms, unrelated JALR, swap and pops in sequence.
        addRow(32'h600, encJalr(5'd1, 5'd1), 1'b0, 32'h0, 1'b0, 1'b0);
        addRow(32'h610, encJalr(5'd5, 5'd5), 1'b0, 32'h0, 1'b0, 1'b0);
        addRow(32'h620, encJalr(5'd2, 5'd3), 1'b0, 32'h0, 1'b0, 1'b0);
        addRow(32'h630, encJalr(5'd1, 5'd5), 1'b1, 32'h614, 1'b0, 1'b0);
        addRow(32'h640, ret1, 1'b1, 32'h634, 1'b0, 1'b0);
        addRow(32'h644, ret1, 1'b1, 32'h604, 1'b1, 1'b0);
        // Swap on an empty stack degenerates to a push.
        addRow(32'h650, encJalr(5'd1, 5'd5), 1'b0, 32'h0, 1'b0, 1'b0);
        addRow(32'h660, ret5, 1'b1, 32'h654, 1'b1, 1'b0);
        // PC+4 wrap and a backward JAL.
        addJal(32'hFFFF_FFFC, 5'd1, 21'h008, 1'b0, 1'b0);
        addRow(32'h670, ret1, 1'b1, 32'h0, 1'b1, 1'b0);
        addJal(32'h1000, 5'd0, 21'h1F_FF00, 1'b1, 1'b0);

        aresetn = 1'b0;
        i_flush = 1'b0;
        i_pc    = '0;
        i_instr = '0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues();
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
        end
        i_valid = 1'b0;
        waitDrain();

        // Backpressure: a return held at the output for three stalled cycles.
        applyStimulus('{32'h700, encJal(5'd1, 21'h040), JAL_PRED, JAL_PRED ? 32'h740 : 32'h0, 1'b0, 1'b0});
        applyStimulus('{32'h710, encJal(5'd1, 21'h040), JAL_PRED, JAL_PRED ? 32'h750 : 32'h0, 1'b0, 1'b0});
        i_valid = 1'b0;
        waitDrain();
        i_ready = 1'b0;
        i_pc    = 32'h800;
        i_instr = ret1;
        i_valid = 1'b1;
        sb.push_back('{32'h800, ret1, 1'b1, 32'h714});
        @(posedge clk);
        #1;
        i_pc = 32'h804;
        repeat (3) begin
            checkOutput("bp_o_ready",    {31'h0, o_ready},     32'h0);
            checkOutput("bp_o_valid",    {31'h0, o_valid},     32'h1);
            checkOutput("bp_o_pc",       o_pc,                 32'h800);
            checkOutput("bp_o_pred_vld", {31'h0, o_pred_vld},  32'h1);
            checkOutput("bp_o_target",   o_pred_target,        32'h714);
            checkOutput("bp_ras_empty",  {31'h0, o_ras_empty}, 32'h0);
            @(posedge clk);
            #1;
        end
        sb.push_back('{32'h804, ret1, 1'b1, 32'h704});
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        checkOutput("bp_ras_empty_end", {31'h0, o_ras_empty}, 32'h1);
        waitDrain();

        // Flush: kills a held output and blocks a same-cycle call.
        i_ready = 1'b0;
        i_pc    = 32'h870;
        i_instr = 32'h0000_0013;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("fl_o_valid_before", {31'h0, o_valid}, 32'h1);
        i_flush = 1'b1;
        i_pc    = 32'h900;
        i_instr = encJal(5'd1, 21'h040);
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_valid = 1'b0;
        checkOutput("fl_o_valid",    {31'h0, o_valid},     32'h0);
        checkOutput("fl_o_pred_vld", {31'h0, o_pred_vld},  32'h0);
        checkOutput("fl_ras_empty",  {31'h0, o_ras_empty}, 32'h1);
        i_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-stream after three calls.
        applyStimulus('{32'hA00, encJal(5'd1, 21'h040), JAL_PRED, JAL_PRED ? 32'hA40 : 32'h0, 1'b0, 1'b0});
        applyStimulus('{32'hA10, encJal(5'd1, 21'h040), JAL_PRED, JAL_PRED ? 32'hA50 : 32'h0, 1'b0, 1'b0});
        applyStimulus('{32'hA20, encJal(5'd1, 21'h040), JAL_PRED, JAL_PRED ? 32'hA60 : 32'h0, 1'b0, 1'b0});
        i_valid = 1'b0;
        aresetn = 1'b0;
        #1;
        sb.delete();
        checkResetValues();
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus('{32'hB00, ret1, 1'b0, 32'h0, 1'b1, 1'b0});
        i_valid = 1'b0;
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
